// File: rtl/irq_request_capture.sv
// Interrupt request front end: synchronises raw requests, latches them as pending bits,
// feeds a priority encoder and presents the winner through a valid/ack handshake.
module irq_request_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 1,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_in,
  input  logic [3:0] mask,
  input  logic [1:0] enc_code,
  output logic [3:0] pend_vis,
  output logic       irq_valid,
  output logic [1:0] irq_id,
  input  logic       irq_ack,
  output logic       timeout,
  output logic [3:0] ovf,
  input  logic [3:0] ovf_clr,
  output logic       busy
);

  localparam int unsigned NSRC  = 4;
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                              state_q, state_d;
  logic [SYNC_STAGES-1:0][NSRC-1:0]    sync_q;
  logic [NSRC-1:0]                     sync_prev_q;
  logic [NSRC-1:0]                     synced;
  logic [NSRC-1:0]                     rise;
  logic [NSRC-1:0]                     set_vec;
  logic [NSRC-1:0]                     clr_vec;
  logic [NSRC-1:0]                     ovf_set;
  logic [NSRC-1:0]                     pending_q;
  logic [NSRC-1:0]                     ovf_q;
  logic [1:0]                          irq_id_q, irq_id_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic                                ack_take;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign rise     = synced & ~sync_prev_q;
  assign set_vec  = (EDGE_MODE != 0) ? rise : synced;
  assign ack_take = (state_q == BUSY) && irq_ack;
  assign clr_vec  = ack_take ? (NSRC'(1) << irq_id_q) : '0;
  assign ovf_set  = (EDGE_MODE != 0) ? (pending_q & rise) : '0;

  assign pend_vis  = pending_q & ~mask;
  assign irq_valid = (state_q == BUSY);
  assign busy      = (state_q != IDLE);
  assign irq_id    = irq_id_q;
  assign ovf       = ovf_q;

  // Synchroniser chains plus previous-value flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      sync_prev_q <= '0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], req_in};
      sync_prev_q <= synced;
    end
  end

  // Pending and overflow bits; a new event wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_vec) | set_vec;
      ovf_q     <= (ovf_q & ~ovf_clr) | ovf_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      irq_id_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      irq_id_q <= irq_id_d;
      cnt_q    <= cnt_d;
    end
  end

  // Presentation FSM; the timeout pulse is suppressed by a same-cycle ack
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    cnt_d    = cnt_q;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pend_vis) begin
          state_d  = BUSY;
          irq_id_d = enc_code;
          cnt_d    = '0;
        end
      end
      BUSY: begin
        if (irq_ack) begin
          state_d = DONE;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
          timeout = 1'b1;
          state_d = DONE;
        end else if (TIMEOUT_CYC != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_irq_request_capture.sv
// Directed bench for irq_request_capture with a cycle-level reference model and
// an every-cycle compare process, plus hand-computed checkpoints.
module tb_irq_request_capture;

  localparam int SYNC = 2;
  localparam int TO   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req_in = '0;
  logic [3:0] mask = '0;
  logic [1:0] enc_code;
  logic [3:0] pend_vis;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic       irq_ack = 1'b0;
  logic       timeout;
  logic [3:0] ovf;
  logic [3:0] ovf_clr = '0;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  // Stand-in for the downstream priority encoder: highest set bit wins
  assign enc_code = pend_vis[3] ? 2'd3 : pend_vis[2] ? 2'd2 : pend_vis[1] ? 2'd1 : 2'd0;

  irq_request_capture #(
    .SYNC_STAGES(SYNC),
    .EDGE_MODE  (1),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .mask     (mask),
    .enc_code (enc_code),
    .pend_vis (pend_vis),
    .irq_valid(irq_valid),
    .irq_id   (irq_id),
    .irq_ack  (irq_ack),
    .timeout  (timeout),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: req history, pending/ovf sets, presentation phase 0=idle 1=presenting 2=gap
  logic [3:0] m_hist [SYNC+1];
  logic [3:0] m_pend, m_ovf;
  int         m_phase, m_cnt;
  logic [1:0] m_id;

  task automatic m_reset();
    for (int j = 0; j <= SYNC; j++) m_hist[j] = '0;
    m_pend = '0; m_ovf = '0; m_phase = 0; m_cnt = 0; m_id = '0;
  endtask

  function automatic logic [1:0] top_bit(input logic [3:0] v);
    logic [1:0] r = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  task automatic m_step();
    logic [3:0] ev, clr, vis;
    ev  = m_hist[SYNC-1] & ~m_hist[SYNC];
    clr = (m_phase == 1 && irq_ack) ? (4'b0001 << m_id) : 4'b0000;
    vis = m_pend & ~mask;
    m_ovf = (m_ovf & ~ovf_clr) | (m_pend & ev);
    case (m_phase)
      0: if (vis != 0) begin m_phase = 1; m_id = top_bit(vis); m_cnt = 0; end
      1: if (irq_ack || m_cnt == TO - 1) m_phase = 2; else m_cnt++;
      default: m_phase = 0;
    endcase
    m_pend = (m_pend & ~clr) | ev;
    for (int j = SYNC; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = req_in;
  endtask

  always @(posedge clk) if (rst_n) m_step();

  // Every-cycle comparison, mid-cycle while inputs are stable
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pend_vis", 8'(pend_vis), 8'(m_pend & ~mask));
      chk("irq_valid", 8'(irq_valid), 8'(m_phase == 1));
      chk("busy", 8'(busy), 8'(m_phase != 0));
      chk("ovf", 8'(ovf), 8'(m_ovf));
      chk("timeout", 8'(timeout), 8'(m_phase == 1 && !irq_ack && m_cnt == TO - 1));
      if (m_phase == 1) chk("irq_id", 8'(irq_id), 8'(m_id));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] v);
    req_in = v;
    tick(1);
    req_in = '0;
  endtask

  initial begin
    m_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 8'(irq_valid), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_pend", 8'(pend_vis), 8'd0);
    chk("rst_ovf", 8'(ovf), 8'd0);
    chk("rst_timeout", 8'(timeout), 8'd0);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick(2);

    // T1: single request latency and handshake
    pulse(4'b0001);
    tick(2);
    chk("t1_not_yet", 8'(irq_valid), 8'd0);
    tick(1);
    chk("t1_valid", 8'(irq_valid), 8'd1);
    chk("t1_id", 8'(irq_id), 8'd0);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    chk("t1_cleared", 8'(pend_vis), 8'd0);
    chk("t1_gap_valid", 8'(irq_valid), 8'd0);
    chk("t1_gap_busy", 8'(busy), 8'd1);
    tick(1);
    chk("t1_idle", 8'(busy), 8'd0);

    // T2: two simultaneous requests, higher first
    pulse(4'b0110);
    tick(3);
    chk("t2_first", 8'(irq_id), 8'd2);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    tick(2);
    chk("t2_second_v", 8'(irq_valid), 8'd1);
    chk("t2_second", 8'(irq_id), 8'd1);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    chk("t2_empty", 8'(pend_vis), 8'd0);
    tick(2);

    // T3: masked source held until unmasked
    mask = 4'b1000;
    pulse(4'b1001);
    tick(3);
    chk("t3_id", 8'(irq_id), 8'd0);
    chk("t3_vis", 8'(pend_vis), 8'b0001);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    tick(2);
    chk("t3_held_idle", 8'(busy), 8'd0);
    mask = 4'b0000;
    #1;
    chk("t3_unmask", 8'(pend_vis), 8'b1000);
    tick(1);
    chk("t3_id_d", 8'(irq_id), 8'd3);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    tick(2);

    // T4: timeout on 4th busy cycle, re-presentation, ack beats timeout
    pulse(4'b0100);
    tick(3);
    tick(3);
    chk("t4_timeout", 8'(timeout), 8'd1);
    tick(1);
    chk("t4_pulse_end", 8'(timeout), 8'd0);
    chk("t4_kept", 8'(pend_vis), 8'b0100);
    tick(2);
    chk("t4_again_v", 8'(irq_valid), 8'd1);
    chk("t4_again_id", 8'(irq_id), 8'd2);
    tick(3);
    irq_ack = 1'b1;
    #1;
    chk("t4_ack_wins", 8'(timeout), 8'd0);
    tick(1);
    irq_ack = 1'b0;
    chk("t4_cleared", 8'(pend_vis), 8'd0);
    tick(2);

    // T5: overflow set/clear, ack coinciding with a new edge
    mask = 4'b0100;
    pulse(4'b0100);
    tick(3);
    chk("t5_no_ovf", 8'(ovf), 8'd0);
    pulse(4'b0100);
    tick(2);
    chk("t5_ovf", 8'(ovf), 8'b0100);
    ovf_clr = 4'b0100; tick(1); ovf_clr = 4'b0000;
    chk("t5_ovf_clr", 8'(ovf), 8'd0);
    mask = 4'b0000;
    req_in = 4'b0100;
    tick(1);
    req_in = 4'b0000;
    chk("t5_busy_id", 8'(irq_id), 8'd2);
    tick(1);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    chk("t5_set_wins", 8'(pend_vis), 8'b0100);
    chk("t5_ovf_again", 8'(ovf), 8'b0100);
    tick(2);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    tick(2);

    // T6: asynchronous reset while presenting
    pulse(4'b0010);
    tick(3);
    chk("t6_pre_valid", 8'(irq_valid), 8'd1);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("t6_valid", 8'(irq_valid), 8'd0);
    chk("t6_pend", 8'(pend_vis), 8'd0);
    chk("t6_ovf", 8'(ovf), 8'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick(6);
    chk("t6_quiet", 8'(busy), 8'd0);
    pulse(4'b1000);
    tick(3);
    chk("t6_new_id", 8'(irq_id), 8'd3);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    tick(3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
